// File: rtl/outer_prod_sched.sv
// -----------------------------------------------------------------------------
// outer_prod_sched
//   Compute-domain controller for the 16x16 outer-product engine. Captures a
//   burst of VEC_LEN operand pairs (A[k], B[k]), then walks the shared
//   multiplier over every (i,j) pair in row-major order. Each product
//   A[i]*B[j] is pushed into the write side of the CDC FIFO.
//
// Ports
//   clk2        compute-domain clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand pair valid this cycle
//   in_matrix_A A element
//   in_matrix_B B element
//   fifo_full   CDC FIFO write-side full
//   fifo_wr     FIFO write strobe
//   fifo_wdata  product A[i]*B[j] (0 when not writing)
//   busy        high in RUN and DONE
//   done        one-cycle pulse after the last product is written
//   drop_err    sticky; in_valid arrived while busy
//
// Handshake: a product transfers on every cycle where fifo_wr=1. fifo_wr is
// raised in RUN exactly when fifo_full=0, so a write never targets a full
// FIFO; while fifo_full=1 the current (i,j) pair is held and retried.
// -----------------------------------------------------------------------------
module outer_prod_sched #(
    parameter int VEC_LEN = 16,
    parameter int DW_IN   = 4,
    parameter int DW_OUT  = 8
) (
    input  logic              clk2,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DW_IN-1:0]  in_matrix_A,
    input  logic [DW_IN-1:0]  in_matrix_B,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [DW_OUT-1:0] fifo_wdata,
    output logic              busy,
    output logic              done,
    output logic              drop_err
);

    localparam int LW = $clog2(VEC_LEN);
    localparam int IW = 2 * LW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            drop_err_q, drop_err_d;

    // Operand register files; contents are don't-care out of reset.
    logic [DW_IN-1:0] a_q [VEC_LEN];
    logic [DW_IN-1:0] b_q [VEC_LEN];

    logic            cap_en;
    logic [LW-1:0]   cap_addr;
    logic            wr_en;
    logic [DW_OUT-1:0] prod;

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        idx_d      = idx_q;
        drop_err_d = drop_err_q;
        cap_en     = 1'b0;
        cap_addr   = ld_cnt_q;
        wr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cap_en   = 1'b1;
                    cap_addr = '0;
                    ld_cnt_d = LW'(1);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                // Gaps in in_valid simply hold ld_cnt.
                if (in_valid) begin
                    cap_en   = 1'b1;
                    ld_cnt_d = ld_cnt_q + LW'(1);
                    if (ld_cnt_q == LW'(VEC_LEN - 1)) begin
                        ld_cnt_d = '0;
                        idx_d    = '0;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                wr_en = !fifo_full;
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
                // idx advances only on a real write; the last write wraps
                // idx to 0 and leaves RUN on the same edge.
                if (wr_en) begin
                    idx_d = idx_q + IW'(1);
                    if (idx_q == {IW{1'b1}}) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ld_cnt_q   <= '0;
            idx_q      <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            idx_q      <= idx_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Register files carry no reset so they map onto plain storage.
    always_ff @(posedge clk2) begin
        if (cap_en) begin
            a_q[cap_addr] <= in_matrix_A;
            b_q[cap_addr] <= in_matrix_B;
        end
    end

    // i = upper half of idx, j = lower half; row-major walk.
    assign prod = DW_OUT'(a_q[idx_q[IW-1:LW]]) * DW_OUT'(b_q[idx_q[LW-1:0]]);

    assign fifo_wr    = wr_en;
    assign fifo_wdata = wr_en ? prod : '0;
    assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_outer_prod_sched.sv
// -----------------------------------------------------------------------------
// tb_outer_prod_sched
//   Self-checking bench for outer_prod_sched. Operand vectors are chosen per
//   burst; the expected product stream is the row-major list of A[i]*B[j]
//   held in exp_q, consumed by a negedge monitor as writes appear.
// -----------------------------------------------------------------------------
module tb_outer_prod_sched;

    logic       clk2 = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_matrix_A;
    logic [3:0] in_matrix_B;
    logic       fifo_full;
    logic       fifo_wr;
    logic [7:0] fifo_wdata;
    logic       busy;
    logic       done;
    logic       drop_err;

    outer_prod_sched dut (
        .clk2        (clk2),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_matrix_A (in_matrix_A),
        .in_matrix_B (in_matrix_B),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_wdata  (fifo_wdata),
        .busy        (busy),
        .done        (done),
        .drop_err    (drop_err)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk2 = ~clk2;

    int cyc = 0;
    always @(posedge clk2) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] a_v[16];
    logic [7:0] b_v[16];
    logic [7:0] wr_log[256];
    int         wr_count     = 0;
    int         first_wr_cyc = 0;
    int         last_wr_cyc  = 0;
    int         done_cnt     = 0;
    int         full_mode    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference: every (i,j) pair in row-major order, product of the vectors.
    function automatic void build_model();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                exp_q.push_back(a_v[i] * b_v[j]);
            end
        end
    endfunction

    // ---------------- fifo_full driver ----------------
    initial begin
        fifo_full = 1'b0;
        forever begin
            @(posedge clk2);
            #1;
            case (full_mode)
                1:       fifo_full = !fifo_full;
                2:       fifo_full = ($urandom_range(0, 3) == 0);
                default: fifo_full = 1'b0;
            endcase
        end
    end

    // ---------------- write monitor ----------------
    always @(negedge clk2) begin
        if (!rst_n) begin
            check_eq("wr_in_reset", 32'(fifo_wr), 32'd0);
        end else begin
            if (fifo_wr) begin
                check_eq("wr_while_full", 32'(fifo_full), 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("extra_wr", wr_count + 1, 32'd256);
                end else begin
                    check_eq("wdata", 32'(fifo_wdata), 32'(exp_q.pop_front()));
                end
                if (wr_count < 256) wr_log[wr_count] = fifo_wdata;
                if (wr_count == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_count++;
            end else begin
                check_eq("wdata_idle", 32'(fifo_wdata), 32'd0);
            end
            if (done) begin
                check_eq("done_latency", cyc - last_wr_cyc, 32'd1);
                check_eq("done_wr_count", wr_count, 32'd256);
                check_eq("done_exp_left", exp_q.size(), 32'd0);
                check_eq("done_no_wr", 32'(fifo_wr), 32'd0);
                done_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge unless noted.
    task automatic load_burst(input int max_gap);
        build_model();
        wr_count = 0;
        for (int k = 0; k < 16; k++) begin
            int gap;
            gap = $urandom_range(0, max_gap);
            repeat (gap) begin
                in_valid = 1'b0;
                @(posedge clk2);
                #1;
            end
            if (k == 8) check_eq("busy_in_load", 32'(busy), 32'd0);
            in_valid    = 1'b1;
            in_matrix_A = a_v[k][3:0];
            in_matrix_B = b_v[k][3:0];
            @(posedge clk2);
            #1;
        end
        in_valid = 1'b0;
        // First write is due in the cycle right after the 16th capture.
        @(negedge clk2);
        check_eq("first_wr", 32'(fifo_wr), 32'(!fifo_full));
        check_eq("busy_run", 32'(busy), 32'd1);
        @(posedge clk2);
        #1;
    endtask

    task automatic wait_writes(input int n);
        for (int k = 0; k < 2000 && wr_count < n; k++) begin
            @(negedge clk2);
            #1;
        end
        if (wr_count < n) check_eq("wr_timeout", wr_count, n);
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int k = 0; k < 2000 && done_cnt == start; k++) begin
            @(negedge clk2);
            #1;
        end
        if (done_cnt == start) begin
            check_eq("done_timeout", done_cnt, start + 1);
        end else begin
            @(negedge clk2);
            #1;
            check_eq("done_one_cycle", 32'(done), 32'd0);
            check_eq("busy_after_done", 32'(busy), 32'd0);
        end
        @(posedge clk2);
        #1;
    endtask

    task automatic rand_vectors();
        for (int k = 0; k < 16; k++) begin
            a_v[k] = 8'($urandom_range(0, 15));
            b_v[k] = 8'($urandom_range(0, 15));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_matrix_A = '0;
        in_matrix_B = '0;
        repeat (3) @(posedge clk2);
        #1;
        check_eq("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        check_eq("rst_wdata", 32'(fifo_wdata), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_drop_err", 32'(drop_err), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk2);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_done", 32'(done), 32'd0);
        end
        @(posedge clk2);
        #1;

        // Ramp vectors, no back-pressure.
        for (int k = 0; k < 16; k++) begin
            a_v[k] = 8'(k);
            b_v[k] = 8'(15 - k);
        end
        full_mode = 0;
        load_burst(0);
        wait_done();
        check_eq("ramp_first", 32'(wr_log[0]), 32'd0);
        check_eq("ramp_idx16", 32'(wr_log[16]), 32'd15);
        check_eq("ramp_last", 32'(wr_log[255]), 32'd0);
        check_eq("ramp_span", last_wr_cyc - first_wr_cyc, 32'd255);
        check_eq("ramp_drop_err", 32'(drop_err), 32'd0);

        // Max operands, full toggling every cycle.
        for (int k = 0; k < 16; k++) begin
            a_v[k] = 8'd15;
            b_v[k] = 8'd15;
        end
        full_mode = 1;
        load_burst(0);
        wait_done();
        check_eq("max_val", 32'(wr_log[100]), 32'd225);
        check_eq("toggle_span", last_wr_cyc - first_wr_cyc, 32'd510);

        // Random vectors delivered with gaps.
        rand_vectors();
        full_mode = 0;
        load_burst(3);
        wait_done();
        check_eq("gap_span", last_wr_cyc - first_wr_cyc, 32'd255);

        // Stray operand during RUN around idx=100 with random back-pressure.
        rand_vectors();
        full_mode = 2;
        load_burst(1);
        wait_writes(100);
        in_valid    = 1'b1;
        in_matrix_A = 4'($urandom_range(0, 15));
        in_matrix_B = 4'($urandom_range(0, 15));
        @(posedge clk2);
        #1;
        in_valid = 1'b0;
        @(negedge clk2);
        check_eq("drop_err_set", 32'(drop_err), 32'd1);
        wait_done();
        check_eq("drop_err_sticky", 32'(drop_err), 32'd1);

        // Reset mid-run at idx=130, then a fresh burst.
        rand_vectors();
        full_mode = 0;
        load_burst(0);
        wait_writes(130);
        @(posedge clk2);
        #1;
        check_eq("pre_abort_wr", 32'(fifo_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_wr", 32'(fifo_wr), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_drop_err", 32'(drop_err), 32'd0);
        check_eq("abort_wr_count", wr_count, 32'd130);
        exp_q.delete();
        repeat (2) @(posedge clk2);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk2);
        #1;
        check_eq("post_abort_idle", 32'(busy), 32'd0);
        rand_vectors();
        full_mode = 2;
        load_burst(2);
        wait_done();
        check_eq("fresh_drop_err", 32'(drop_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "timeout");
    end

endmodule
